// File: rtl/au_pkg.sv
// Shared definitions for the au_param_pipe arithmetic unit: opcode width and
// the opcode enumeration used by the pipeline and its testbench.
package au_pkg;

   localparam int AU_OP_W = 2;

   typedef enum logic [AU_OP_W-1:0] {
      AU_ADD = 2'b00,
      AU_SUB = 2'b01,
      AU_MAX = 2'b10,
      AU_MIN = 2'b11
   } au_op_e;

endpackage

// File: rtl/au_addsub.sv
// W-bit adder/subtractor with carry-in. Subtraction is a + ~b + 1 so a single
// adder serves ADD, SUB and the MAX/MIN comparison. ovf_s is the
// two's-complement overflow of the operation actually performed.
module au_addsub #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf_s
);

   logic [W-1:0] b_eff_s;
   logic [W:0]   full_s;

   // Invert b for subtraction and feed sub in as the carry
   always_comb begin
      b_eff_s = sub ? ~b : b;
      full_s  = {1'b0, a} + {1'b0, b_eff_s} + {{W{1'b0}}, sub};
   end

   assign sum   = full_s[W-1:0];
   assign cout  = full_s[W];
   // Operands of equal sign producing a result of the other sign
   assign ovf_s = (a[W-1] == b_eff_s[W-1]) && (full_s[W-1] != a[W-1]);

endmodule

// File: rtl/au_param_pipe.sv
// Two-stage valid/ready arithmetic pipeline: ADD, SUB, MAX, MIN.
// S1 captures the shared adder result with its operands; S2 selects and
// registers y/ovf/zero. Define AU_SAT_EN to clamp overflowing ADD/SUB results
// to the representable extreme instead of wrapping.
module au_param_pipe
   import au_pkg::*;
#(
   parameter int W      = 8,
   parameter bit SIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       a,
   input  logic [W-1:0]       b,
   input  logic [AU_OP_W-1:0] op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W-1:0]       y,
   output logic               ovf,
   output logic               zero
);

   localparam logic [W-1:0] Y_ZERO = {W{1'b0}};
`ifdef AU_SAT_EN
   localparam logic [W-1:0] Y_ONES = {W{1'b1}};
   localparam logic [W-1:0] Y_SMAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] Y_SMIN = {1'b1, {(W-1){1'b0}}};
`endif

   // adder (stage-1 combinational)
   logic [W-1:0] add_sum_s;
   logic         add_cout_s;
   logic         add_ovf_s;
   logic         sub_s;

   // stage 1 registers
   logic         s1_valid_r;
   logic [W-1:0] s1_a_r;
   logic [W-1:0] s1_b_r;
   au_op_e       s1_op_r;
   logic [W:0]   s1_sum_r;
   logic         s1_sovf_r;

   // stage 2 registers
   logic         s2_valid_r;
   logic [W-1:0] s2_y_r;
   logic         s2_ovf_r;
   logic         s2_zero_r;

   // handshake and result select
   logic         s2_load_s;
   logic         accept_s;
   logic         lt_s;
   logic         eq_s;
   logic [W-1:0] res_y_s;
   logic         res_ovf_s;
   logic [W-1:0] fin_y_s;

   // Everything except ADD needs a - b (MAX/MIN compare through the same adder)
   assign sub_s = (op != AU_ADD);

   au_addsub #(.W(W)) u_addsub (
      .a     (a),
      .b     (b),
      .sub   (sub_s),
      .sum   (add_sum_s),
      .cout  (add_cout_s),
      .ovf_s (add_ovf_s)
   );

   // S2 takes new content when empty or when its result leaves this cycle;
   // S1 can accept when empty or when it moves into S2
   assign s2_load_s = !s2_valid_r || out_ready;
   assign in_ready  = !rst && (!s1_valid_r || s2_load_s);
   assign accept_s  = in_valid && in_ready;

   // Stage 1: capture operands, opcode and the W+1-bit adder result
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_a_r     <= Y_ZERO;
         s1_b_r     <= Y_ZERO;
         s1_op_r    <= AU_ADD;
         s1_sum_r   <= {(W+1){1'b0}};
         s1_sovf_r  <= 1'b0;
      end else begin
         if (in_ready) begin
            s1_valid_r <= in_valid;
         end
         if (accept_s) begin
            s1_a_r    <= a;
            s1_b_r    <= b;
            s1_op_r   <= au_op_e'(op);
            s1_sum_r  <= {add_cout_s, add_sum_s};
            s1_sovf_r <= add_ovf_s;
         end
      end
   end

   // Result select: true a<b uses overflow-corrected sign or borrow, never the raw MSB
   always_comb begin
      lt_s      = SIGNED ? (s1_sum_r[W-1] ^ s1_sovf_r) : !s1_sum_r[W];
      eq_s      = (s1_sum_r[W-1:0] == Y_ZERO);
      res_y_s   = s1_a_r;
      res_ovf_s = 1'b0;
      case (s1_op_r)
         AU_ADD: begin
            res_y_s   = s1_sum_r[W-1:0];
            res_ovf_s = SIGNED ? s1_sovf_r : s1_sum_r[W];
         end
         AU_SUB: begin
            res_y_s   = s1_sum_r[W-1:0];
            res_ovf_s = SIGNED ? s1_sovf_r : !s1_sum_r[W];
         end
         AU_MAX: begin
            res_y_s = lt_s ? s1_b_r : s1_a_r;
         end
         AU_MIN: begin
            res_y_s = (lt_s || eq_s) ? s1_a_r : s1_b_r;
         end
         default: begin
            res_y_s   = s1_a_r;
            res_ovf_s = 1'b0;
         end
      endcase
   end

`ifdef AU_SAT_EN
   logic [W-1:0] sat_val_s;

   // Clamp target: signed overflow direction follows the sign of a
   always_comb begin
      if (SIGNED) begin
         sat_val_s = s1_a_r[W-1] ? Y_SMIN : Y_SMAX;
      end else begin
         sat_val_s = (s1_op_r == AU_SUB) ? Y_ZERO : Y_ONES;
      end
   end

   assign fin_y_s = res_ovf_s ? sat_val_s : res_y_s;
`else
   assign fin_y_s = res_y_s;
`endif

   // Stage 2: register the final result; held while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_r <= 1'b0;
         s2_y_r     <= Y_ZERO;
         s2_ovf_r   <= 1'b0;
         s2_zero_r  <= 1'b0;
      end else if (s2_load_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_y_r    <= fin_y_s;
            s2_ovf_r  <= res_ovf_s;
            s2_zero_r <= (fin_y_s == Y_ZERO);
         end
      end
   end

   assign out_valid = s2_valid_r;
   assign y         = s2_y_r;
   assign ovf       = s2_ovf_r;
   assign zero      = s2_zero_r;

endmodule

// File: tb/tb_au_param_pipe.sv
// Self-checking bench for au_param_pipe: directed W=8 signed/unsigned cases,
// streaming, stall and reset scenarios, then random W=16 signed traffic
// against an integer-arithmetic reference model. Honors AU_SAT_EN.
module tb_au_param_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // W=8 pair (signed and unsigned) share one stimulus
   logic       in_valid8, out_ready8;
   logic [7:0] a8, b8;
   logic [1:0] op8;
   logic       in_ready_s8, out_valid_s8, ovf_s8, zero_s8;
   logic [7:0] y_s8;
   logic       in_ready_u8, out_valid_u8, ovf_u8, zero_u8;
   logic [7:0] y_u8;

   // W=16 signed
   logic        in_valid16, out_ready16;
   logic [15:0] a16, b16;
   logic [1:0]  op16;
   logic        in_ready16, out_valid16, ovf16, zero16;
   logic [15:0] y16;

   au_param_pipe #(.W(8), .SIGNED(1'b1)) dut_s8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready_s8),
      .a(a8), .b(b8), .op(op8), .out_valid(out_valid_s8), .out_ready(out_ready8),
      .y(y_s8), .ovf(ovf_s8), .zero(zero_s8));

   au_param_pipe #(.W(8), .SIGNED(1'b0)) dut_u8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready_u8),
      .a(a8), .b(b8), .op(op8), .out_valid(out_valid_u8), .out_ready(out_ready8),
      .y(y_u8), .ovf(ovf_u8), .zero(zero_u8));

   au_param_pipe #(.W(16), .SIGNED(1'b1)) dut_s16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
      .y(y16), .ovf(ovf16), .zero(zero16));

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] ys;
      logic       os;
      logic       zs;
      logic [7:0] yu;
      logic       ou;
      logic       zu;
   } exp8_t;

   exp8_t       q8[$];
   logic [65:0] q16[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the mathematical operand values.
   // Returns {zero, ovf, y}.
   function automatic logic [65:0] ref_op(input int w, input bit sgn,
                                          input logic [63:0] ia, input logic [63:0] ib,
                                          input logic [1:0] iop);
      longint one = 64'sd1;
      longint va, vb, r, mx, mn, modv;
      logic [63:0] yy;
      logic ov;
      modv = one << w;
      if (sgn) begin
         va = ia[w-1] ? longint'(ia) - modv : longint'(ia);
         vb = ib[w-1] ? longint'(ib) - modv : longint'(ib);
         mx = (one << (w-1)) - 1;
         mn = -(one << (w-1));
      end else begin
         va = longint'(ia);
         vb = longint'(ib);
         mx = modv - 1;
         mn = 0;
      end
      case (iop)
         2'd0:    r = va + vb;
         2'd1:    r = va - vb;
         2'd2:    r = (va >= vb) ? va : vb;
         default: r = (va <= vb) ? va : vb;
      endcase
      ov = (iop < 2'd2) && ((r > mx) || (r < mn));
`ifdef AU_SAT_EN
      if (ov) r = (r > mx) ? mx : mn;
`endif
      yy = 64'(r) & 64'(modv - 1);
      return {(yy == 64'd0), ov, yy};
   endfunction

   // One W=8 cycle: drive at negedge, record accepts, check delivered results
   task automatic cyc8(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [1:0] iop, input logic ordy);
      exp8_t e;
      logic [65:0] rs, ru;
      @(negedge clk);
      in_valid8 = iv; a8 = ia; b8 = ib; op8 = iop; out_ready8 = ordy;
      #1;
      if (iv && in_ready_s8) begin
         rs = ref_op(8, 1'b1, {56'd0, ia}, {56'd0, ib}, iop);
         ru = ref_op(8, 1'b0, {56'd0, ia}, {56'd0, ib}, iop);
         e.ys = rs[7:0]; e.os = rs[64]; e.zs = rs[65];
         e.yu = ru[7:0]; e.ou = ru[64]; e.zu = ru[65];
         q8.push_back(e);
      end
      if (out_valid_s8 && ordy) begin
         chk("w8.have_expected", q8.size() != 0, 1'b1);
         if (q8.size() != 0) begin
            e = q8.pop_front();
            chk("s8.y", y_s8, e.ys);
            chk("s8.ovf", ovf_s8, e.os);
            chk("s8.zero", zero_s8, e.zs);
            chk("u8.out_valid", out_valid_u8, 1'b1);
            chk("u8.y", y_u8, e.yu);
            chk("u8.ovf", ovf_u8, e.ou);
            chk("u8.zero", zero_u8, e.zu);
         end
      end
   endtask

   // Single operation with explicit expected values, latency checked
   task automatic single8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic [1:0] iop, input bit uns,
                          input logic [7:0] ey, input logic eo, input logic ez);
      cyc8(1'b1, ia, ib, iop, 1'b1);
      chk({tag, ".in_ready"}, in_ready_s8, 1'b1);
      cyc8(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
      chk({tag, ".lat1_out_valid"}, out_valid_s8, 1'b0);
      @(negedge clk);
      #1;
      chk({tag, ".lat2_out_valid"}, out_valid_s8, 1'b1);
      chk({tag, ".y"}, uns ? y_u8 : y_s8, ey);
      chk({tag, ".ovf"}, uns ? ovf_u8 : ovf_s8, eo);
      chk({tag, ".zero"}, uns ? zero_u8 : zero_s8, ez);
      // result drains at the next edge; drop its scoreboard entry
      if (q8.size() != 0) void'(q8.pop_front());
   endtask

   initial begin
      logic [65:0] r16;
      rst = 1'b1;
      in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = 8'h00; b8 = 8'h00; op8 = 2'd0;
      in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = 16'h0000; b16 = 16'h0000; op16 = 2'd0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst.in_ready", in_ready_s8, 1'b0);
      chk("rst.out_valid", out_valid_s8, 1'b0);
      chk("rst.y", y_s8, 8'h00);
      chk("rst.ovf", ovf_s8, 1'b0);
      chk("rst.zero", zero_s8, 1'b0);
      chk("rst.out_valid16", out_valid16, 1'b0);
      rst = 1'b0;
      #1;
      chk("rel.in_ready", in_ready_s8, 1'b1);
      chk("rel.in_ready16", in_ready16, 1'b1);

      // Directed boundary cases
`ifdef AU_SAT_EN
      single8("add_ovf", 8'd100, 8'd50, 2'd0, 1'b0, 8'h7F, 1'b1, 1'b0);
      single8("subs_ovf", 8'h80, 8'h01, 2'd1, 1'b0, 8'h80, 1'b1, 1'b0);
      single8("subu_borrow", 8'd3, 8'd5, 2'd1, 1'b1, 8'h00, 1'b1, 1'b1);
`else
      single8("add_ovf", 8'd100, 8'd50, 2'd0, 1'b0, 8'h96, 1'b1, 1'b0);
      single8("subs_ovf", 8'h80, 8'h01, 2'd1, 1'b0, 8'h7F, 1'b1, 1'b0);
      single8("subu_borrow", 8'd3, 8'd5, 2'd1, 1'b1, 8'hFE, 1'b1, 1'b0);
`endif
      single8("max_s", 8'h7F, 8'h80, 2'd2, 1'b0, 8'h7F, 1'b0, 1'b0);
      single8("min_s", 8'h7F, 8'h80, 2'd3, 1'b0, 8'h80, 1'b0, 1'b0);
      single8("max_u", 8'h7F, 8'h80, 2'd2, 1'b1, 8'h80, 1'b0, 1'b0);
      single8("subu_eq", 8'd5, 8'd5, 2'd1, 1'b1, 8'h00, 1'b0, 1'b1);
      single8("adds_neg", 8'hFF, 8'hFE, 2'd0, 1'b0, 8'hFD, 1'b0, 1'b0);

      // Back-to-back stream of 10 ops
      for (int c = 0; c < 14; c++) begin
         cyc8(c < 10, 8'($urandom), 8'($urandom), 2'($urandom), 1'b1);
         if (c < 10) chk("stream.in_ready", in_ready_s8, 1'b1);
         chk("stream.out_valid", out_valid_s8, (c >= 2) && (c < 12));
      end
      chk("stream.all_delivered", q8.size(), 0);

      // Stall: out_ready low, two accepts fill the pipe
      cyc8(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0);
      chk("stall.acc0", in_ready_s8, 1'b1);
      cyc8(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0);
      chk("stall.acc1", in_ready_s8, 1'b1);
      for (int c = 0; c < 3; c++) begin
         cyc8(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0);
         chk("stall.in_ready", in_ready_s8, 1'b0);
         chk("stall.out_valid", out_valid_s8, 1'b1);
         chk("stall.y_held", y_s8, q8[0].ys);
         chk("stall.ovf_held", ovf_s8, q8[0].os);
      end
      for (int c = 0; c < 4; c++) cyc8(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
      chk("stall.all_delivered", q8.size(), 0);

      // Reset with two operations in flight
      cyc8(1'b1, 8'd1, 8'd2, 2'd0, 1'b0);
      cyc8(1'b1, 8'd3, 8'd4, 2'd0, 1'b0);
      @(negedge clk);
      rst = 1'b1; in_valid8 = 1'b0;
      #1;
      chk("midrst.in_ready", in_ready_s8, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst.out_valid", out_valid_s8, 1'b0);
      chk("midrst.in_ready_after", in_ready_s8, 1'b1);
      q8.delete();
      for (int c = 0; c < 4; c++) begin
         cyc8(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
         chk("midrst.no_ghost", out_valid_s8, 1'b0);
      end

      // W=16 signed random traffic against the scoreboard
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         in_valid16  = ($urandom_range(0, 3) != 0);
         out_ready16 = ($urandom_range(0, 3) != 0);
         op16 = 2'($urandom);
         case ($urandom_range(0, 5))
            0:       a16 = 16'h7FFF;
            1:       a16 = 16'h8000;
            default: a16 = 16'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0:       b16 = 16'h7FFF;
            1:       b16 = a16;
            default: b16 = 16'($urandom);
         endcase
         #1;
         if (in_valid16 && in_ready16)
            q16.push_back(ref_op(16, 1'b1, {48'd0, a16}, {48'd0, b16}, op16));
         if (out_valid16 && out_ready16) begin
            chk("w16.have_expected", q16.size() != 0, 1'b1);
            if (q16.size() != 0) begin
               r16 = q16.pop_front();
               chk("w16.y", y16, r16[15:0]);
               chk("w16.ovf", ovf16, r16[64]);
               chk("w16.zero", zero16, r16[65]);
            end
         end
      end
      // Drain remaining W=16 results
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         in_valid16 = 1'b0; out_ready16 = 1'b1;
         #1;
         if (out_valid16) begin
            chk("w16d.have_expected", q16.size() != 0, 1'b1);
            if (q16.size() != 0) begin
               r16 = q16.pop_front();
               chk("w16d.y", y16, r16[15:0]);
               chk("w16d.ovf", ovf16, r16[64]);
               chk("w16d.zero", zero16, r16[65]);
            end
         end
      end
      chk("w16.all_delivered", q16.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/au_param_pipe.md
AU_PARAM_PIPE -- requirements
Module: au_param_pipe

Interface
REQ-001 Parameter W, default 8: operand/result width; legal range 2..64.
REQ-002 Parameter SIGNED, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set a/b/op presented.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 a, b  input  W  operands.
REQ-008 op  input  2  opcode: 00 ADD, 01 SUB (a-b), 10 MAX, 11 MIN.
REQ-009 out_valid  output  1  result y/ovf/zero valid.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 y  output  W  result.
REQ-012 ovf  output  1  ADD/SUB result not representable in W bits under SIGNED rules.
REQ-013 zero  output  1  y equals 0.

Function
REQ-014 Input transfer occurs on a cycle with in_valid=1 and in_ready=1; output transfer occurs on a cycle with out_valid=1 and out_ready=1.
REQ-015 Two register stages: S1 registers the W+1-bit adder/subtractor result plus a, b and op; S2 registers y, ovf and zero; latency is exactly 2 cycles from input transfer to out_valid with no stall.
REQ-016 Each stage holds a valid bit; a stage loads when it is empty or its content moves downstream in the same cycle.
REQ-017 in_ready = !S1_valid | (S1 advances this cycle); full throughput is one operation per cycle while out_ready=1.
REQ-018 When out_valid=1 and out_ready=0, y/ovf/zero/out_valid SHALL hold stable and no accepted operation SHALL be lost or duplicated (maximum 2 in flight).
REQ-019 SUB SHALL be computed as a + ~b + 1 in a single shared adder; ADD uses a + b + 0.
REQ-020 MAX/MIN SHALL use a true comparison (overflow-corrected sign for SIGNED=1, borrow for SIGNED=0), never the raw MSB of a-b; for equal operands the result is a.
REQ-021 For SIGNED=1, ovf = operand sign(s) agree and result sign differs (ADD: signs of a,b; SUB: signs of a,~b); for SIGNED=0, ovf = carry out (ADD) or borrow (SUB).
REQ-022 ovf SHALL be 0 for MAX and MIN.
REQ-023 Without saturation, the ADD/SUB result wraps modulo 2^W.
REQ-024 Simultaneous output transfer and input transfer SHALL both complete in the same cycle.

Reset
REQ-025 While rst=1: S1_valid=0, S2_valid=0, out_valid=0, y=0, ovf=0, zero=0, and in_ready=0.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight operations; the first cycle after rst is deasserted has in_ready=1.

Configuration
REQ-027 With macro AU_SAT_EN defined, an overflowing ADD/SUB SHALL clamp y to the representable extreme: SIGNED=1 gives max positive or min negative by direction; SIGNED=0 gives all-ones for ADD and 0 for SUB. ovf SHALL still be reported.
REQ-028 Without AU_SAT_EN, the wrap behaviour of REQ-023 applies and no saturation logic is generated.

Structure
REQ-029 Shared package au_pkg SHALL hold the opcode enum typedef (AU_ADD, AU_SUB, AU_MAX, AU_MIN) and the opcode width constant.
REQ-030 The W-bit adder/subtractor with carry-in SHALL be a sub-module au_addsub (combinational: a, b, sub -> sum[W-1:0], cout, ovf_s); the pipeline registers and result select reside in au_param_pipe.

Verification
REQ-031 W=8, SIGNED=1, ADD 100+50 -> y=0x96, ovf=1 two cycles later; with AU_SAT_EN -> y=0x7F, ovf=1.
REQ-032 W=8, SIGNED=1, MAX a=0x7F, b=0x80 -> y=0x7F (no sign-of-difference error); MIN same operands -> y=0x80; ovf=0 for both.
REQ-033 W=8, SIGNED=0, SUB 3-5 -> y=0xFE, ovf=1; with AU_SAT_EN -> y=0x00, ovf=1; SUB 5-5 -> y=0, zero=1.
REQ-034 Back-to-back stream of 10 ops with out_ready=1 -> 10 results in order at 1 per cycle, first result 2 cycles after first accept; with out_ready held 0 for 3 cycles -> in_ready drops after 2 accepts, results stay stable, no loss.
REQ-035 rst pulsed with 2 ops in flight -> out_valid=0 on the next cycle, neither result ever appears, in_ready=1 on the cycle after rst falls.
REQ-036 W=16, SIGNED=1 random ADD/SUB/MAX/MIN with random in_valid/out_ready -> scoreboard match on y, ovf and zero for every transfer.
